// File: rtl/mult16_seq8_pkg.sv
// rtl/mult16_seq8_pkg.sv - shared types, partial-product tables and helpers for mult16_seq8_ctrl
package mult16_seq8_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int PP_COUNT = 4;

    // Partial product k uses these accumulator shifts and operand byte selects
    localparam logic [4:0] PP_SHIFT [PP_COUNT] = '{5'd0, 5'd8, 5'd8, 5'd16};
    localparam logic [PP_COUNT-1:0] PP_A_HI = 4'b1100;
    localparam logic [PP_COUNT-1:0] PP_B_HI = 4'b1010;

    // -32768 maps to 0x8000, which is the correct unsigned magnitude
    function automatic logic [15:0] abs16(input logic [15:0] v);
        return v[15] ? 16'(~v + 16'd1) : v;
    endfunction

endpackage

// File: rtl/mult16_seq8_ctrl.sv
// rtl/mult16_seq8_ctrl.sv - 16x16 signed multiply built from four passes through a shared 8x8 unsigned core
module mult16_seq8_ctrl
    import mult16_seq8_pkg::*;
#(
    parameter int MUL_LAT = 0
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    input  logic        i_abort,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_z,
    output logic        o_busy,
    output logic        o_mm_en,
    output logic [7:0]  o_mm_a,
    output logic [7:0]  o_mm_b,
    input  logic [15:0] i_mm_p
);

    localparam logic [1:0] WAIT_LAST = 2'(MUL_LAT - 1);
    localparam logic [1:0] K_LAST    = 2'(PP_COUNT - 1);

    state_e      state;
    logic        sgn;
    logic [15:0] ma;
    logic [15:0] mb;
    logic [31:0] acc;
    logic [1:0]  k;
    logic [1:0]  wcnt;

    logic [7:0]  sel_a;
    logic [7:0]  sel_b;
    logic [31:0] pp;
    logic [31:0] sum;
    logic        add_now;
    logic        active;

    always_comb begin
        sel_a   = PP_A_HI[k] ? ma[15:8] : ma[7:0];
        sel_b   = PP_B_HI[k] ? mb[15:8] : mb[7:0];
        pp      = 32'(i_mm_p) << PP_SHIFT[k];
        sum     = acc + pp;
        active  = (state == ST_ISSUE) || (state == ST_WAIT);
        // The core product is taken in ISSUE when there is no latency, else on the last WAIT cycle
        add_now = ((state == ST_ISSUE) && (MUL_LAT == 0)) ||
                  ((state == ST_WAIT) && (wcnt == WAIT_LAST));
    end

    assign o_ready = (state == ST_IDLE);
    assign o_valid = (state == ST_DONE);
    assign o_busy  = (state != ST_IDLE);
    assign o_mm_en = (state == ST_ISSUE);
    assign o_mm_a  = active ? sel_a : 8'd0;
    assign o_mm_b  = active ? sel_b : 8'd0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_IDLE;
            sgn   <= 1'b0;
            ma    <= '0;
            mb    <= '0;
            acc   <= '0;
            k     <= '0;
            wcnt  <= '0;
            o_z   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_valid) begin
                        sgn  <= i_a[15] ^ i_b[15];
                        ma   <= abs16(i_a);
                        mb   <= abs16(i_b);
                        acc  <= '0;
                        k    <= '0;
                        wcnt <= '0;
                        if ((i_a == 16'd0) || (i_b == 16'd0)) begin
                            o_z   <= '0;
                            state <= ST_DONE;
                        end else begin
                            state <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE, ST_WAIT: begin
                    if (i_abort) begin
                        acc   <= '0;
                        k     <= '0;
                        wcnt  <= '0;
                        state <= ST_IDLE;
                    end else if (add_now) begin
                        wcnt <= '0;
                        if (k == K_LAST) begin
                            acc   <= sum;
                            o_z   <= sgn ? (~sum + 32'd1) : sum;
                            state <= ST_DONE;
                        end else begin
                            acc   <= sum;
                            k     <= k + 2'd1;
                            state <= ST_ISSUE;
                        end
                    end else if (state == ST_ISSUE) begin
                        wcnt  <= '0;
                        state <= ST_WAIT;
                    end else begin
                        wcnt <= wcnt + 2'd1;
                    end
                end
                ST_DONE: begin
                    if (i_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult16_seq8_ctrl.sv
// tb/tb_mult16_seq8_ctrl.sv - randomized self-checking bench for mult16_seq8_ctrl at MUL_LAT 0 and 2
module tb_mult16_seq8_ctrl;

    localparam int LAT [2] = '{0, 2};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        vld   [2];
    logic        rdy   [2];
    logic        abt   [2];
    logic        ovld  [2];
    logic        drdy  [2];
    logic        busy  [2];
    logic        mm_en [2];
    logic [15:0] ia    [2];
    logic [15:0] ib    [2];
    logic [31:0] oz    [2];
    logic [7:0]  mm_a  [2];
    logic [7:0]  mm_b  [2];
    logic [15:0] mm_p0;
    logic [15:0] mm_p1;
    logic [15:0] p_d1;
    logic [15:0] p_d2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mult16_seq8_ctrl #(.MUL_LAT(0)) u_lat0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(vld[0]), .o_ready(rdy[0]),
        .i_a(ia[0]), .i_b(ib[0]), .i_abort(abt[0]), .o_valid(ovld[0]),
        .i_ready(drdy[0]), .o_z(oz[0]), .o_busy(busy[0]), .o_mm_en(mm_en[0]),
        .o_mm_a(mm_a[0]), .o_mm_b(mm_b[0]), .i_mm_p(mm_p0)
    );

    mult16_seq8_ctrl #(.MUL_LAT(2)) u_lat2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(vld[1]), .o_ready(rdy[1]),
        .i_a(ia[1]), .i_b(ib[1]), .i_abort(abt[1]), .o_valid(ovld[1]),
        .i_ready(drdy[1]), .o_z(oz[1]), .o_busy(busy[1]), .o_mm_en(mm_en[1]),
        .o_mm_a(mm_a[1]), .o_mm_b(mm_b[1]), .i_mm_p(mm_p1)
    );

    // Exact 8x8 cores: combinational for latency 0, two register stages for latency 2
    assign mm_p0 = 16'(mm_a[0]) * 16'(mm_b[0]);
    always @(posedge clk) begin
        p_d1 <= 16'(mm_a[1]) * 16'(mm_b[1]);
        p_d2 <= p_d1;
    end
    assign mm_p1 = p_d2;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_prod(input logic [15:0] a, input logic [15:0] b);
        int sa;
        int sb;
        sa = $signed(a);
        sb = $signed(b);
        return 32'(sa * sb);
    endfunction

    function automatic logic [15:0] ref_pair(input logic [15:0] a, input logic [15:0] b, input int kk);
        int sa;
        int sb;
        logic [15:0] mav;
        logic [15:0] mbv;
        sa  = $signed(a);
        sb  = $signed(b);
        mav = 16'((sa < 0) ? -sa : sa);
        mbv = 16'((sb < 0) ? -sb : sb);
        return {(kk >= 2) ? mav[15:8] : mav[7:0], (kk % 2 == 1) ? mbv[15:8] : mbv[7:0]};
    endfunction

    task automatic run_op(input int u, input logic [15:0] a, input logic [15:0] b,
                          input int hold, input bit abort_at_accept);
        logic [31:0] exp_z;
        logic [15:0] ops [$];
        logic        ens [$];
        int          n;
        int          per;
        bit          zero;
        exp_z = ref_prod(a, b);
        zero  = (a == 16'd0) || (b == 16'd0);
        per   = LAT[u] + 1;
        n = 0;
        while (!rdy[u] && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("ready_before_accept", 32'(rdy[u]), 32'd1);
        vld[u] = 1'b1;
        ia[u]  = a;
        ib[u]  = b;
        abt[u] = abort_at_accept;
        @(negedge clk);
        vld[u] = 1'b0;
        abt[u] = 1'b0;
        ia[u]  = 16'($urandom);
        ib[u]  = 16'($urandom);
        n = 0;
        while (!ovld[u] && n < 200) begin
            ops.push_back({mm_a[u], mm_b[u]});
            ens.push_back(mm_en[u]);
            @(negedge clk);
            n++;
        end
        check("latency", 32'(n), zero ? 32'd0 : 32'(4 * per));
        if (ops.size() == n && n == 4 * per) begin
            for (int i = 0; i < n; i++) begin
                check("mm_operands", 32'(ops[i]), 32'(ref_pair(a, b, i / per)));
                if (i % per == 0) check("mm_en_issue", 32'(ens[i]), 32'd1);
            end
        end
        for (int h = 0; h < hold; h++) begin
            check("hold_valid", 32'(ovld[u]), 32'd1);
            check("hold_z", oz[u], exp_z);
            check("hold_ready", 32'(rdy[u]), 32'd0);
            vld[u] = 1'b1;
            ia[u]  = 16'($urandom);
            ib[u]  = 16'($urandom);
            @(negedge clk);
        end
        check("result_z", oz[u], exp_z);
        check("result_valid", 32'(ovld[u]), 32'd1);
        check("done_mm_idle", 32'({mm_en[u], mm_a[u], mm_b[u]}), 32'd0);
        drdy[u] = 1'b1;
        @(negedge clk);
        drdy[u] = 1'b0;
        vld[u]  = 1'b0;
        check("ready_after_handshake", 32'(rdy[u]), 32'd1);
        check("valid_after_handshake", 32'(ovld[u]), 32'd0);
        check("busy_after_handshake", 32'(busy[u]), 32'd0);
    endtask

    task automatic cancel_op(input int u, input logic [15:0] a, input logic [15:0] b, input bit use_reset);
        bit seen;
        vld[u] = 1'b1;
        ia[u]  = a;
        ib[u]  = b;
        @(negedge clk);
        vld[u] = 1'b0;
        repeat (2 * (LAT[u] + 1)) @(negedge clk);
        check("k2_operands", 32'({mm_a[u], mm_b[u]}), 32'(ref_pair(a, b, 2)));
        check("k2_busy", 32'(busy[u]), 32'd1);
        if (use_reset) rst_n = 1'b0;
        else abt[u] = 1'b1;
        @(negedge clk);
        rst_n  = 1'b1;
        abt[u] = 1'b0;
        check("cancel_ready", 32'(rdy[u]), 32'd1);
        check("cancel_valid", 32'(ovld[u]), 32'd0);
        check("cancel_mm", 32'({mm_en[u], mm_a[u], mm_b[u]}), 32'd0);
        if (use_reset) check("reset_z", oz[u], 32'd0);
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (ovld[u]) seen = 1'b1;
        end
        check("no_valid_after_cancel", 32'(seen), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        rst_n = 1'b0;
        for (int u = 0; u < 2; u++) begin
            vld[u] = 1'b0; abt[u] = 1'b0; drdy[u] = 1'b0; ia[u] = '0; ib[u] = '0;
        end
        repeat (2) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            check("reset_ready", 32'(rdy[u]), 32'd1);
            check("reset_valid", 32'(ovld[u]), 32'd0);
            check("reset_z", oz[u], 32'd0);
            check("reset_busy", 32'(busy[u]), 32'd0);
            check("reset_mm", 32'({mm_en[u], mm_a[u], mm_b[u]}), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        run_op(0, 16'd300, 16'hFF38, 0, 1'b0);
        run_op(0, 16'h8000, 16'h8000, 0, 1'b0);
        run_op(0, 16'h8000, 16'd1, 0, 1'b0);
        run_op(0, 16'd0, 16'd12345, 0, 1'b0);
        run_op(0, 16'd7, 16'd9, 3, 1'b0);
        run_op(1, 16'd255, 16'd257, 0, 1'b0);
        run_op(1, 16'h8000, 16'h8000, 2, 1'b0);
        run_op(0, 16'd5, 16'd6, 0, 1'b1);
        cancel_op(0, 16'd1000, 16'd1000, 1'b0);
        cancel_op(1, 16'd1000, 16'd1000, 1'b0);
        run_op(0, 16'hFFFD, 16'd5, 0, 1'b0);
        cancel_op(0, 16'd1000, 16'd1000, 1'b1);
        run_op(0, 16'hFFFD, 16'd5, 0, 1'b0);
        run_op(1, 16'hFFFD, 16'd5, 1, 1'b0);

        for (int i = 0; i < 40; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if ($urandom_range(0, 9) == 0) ra = 16'd0;
            if ($urandom_range(0, 9) == 0) rb = 16'd0;
            run_op(i % 2, ra, rb, $urandom_range(0, 3), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
